regfile_arbiter: RTL

Two-port arbiter and access sequencer for the AXI-Lite backend register file. It shares the single write/read port pair of the register file between port A (AXI-Lite slave) and port B (local/DMA master). Each accepted request is sequenced as exactly one register-file access, and a response is returned with backpressure. Ports are selected fairly with a round-robin scheme.

---
 rtl/regfile_arb_pkg.sv | 19 +
 rtl/rr_arbiter_2.sv | 28 ++
 rtl/regfile_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
//   state_t      : sequencer states (IDLE -> ACCESS -> RESP -> IDLE)
//   RESP_*       : response codes returned to requesters
//   PORT_A/B     : requester ids, also the encoding of last_gnt
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant logic, purely combinational.
//   req[1:0]  : request lines (bit 0 = port A, bit 1 = port B)
//   last_gnt  : id of the port granted most recently (register lives in parent)
//   en        : grants are only issued while enabled
//   gnt[1:0]  : one-hot grant, all zero when disabled or nobody requests
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  input  logic       en,
  output logic [1:0] gnt
);

  // NOTE: gnt gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        // On a tie the port that did not win last time goes first.
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Shares one register-file read/write port pair between requester A
// (AXI-Lite slave side) and requester B (local/DMA master). Each accepted
// request becomes exactly one register-file access followed by a held
// response.
//   clk, rst_n              : clock, asynchronous active-low reset
//   {a,b}_valid/ready       : request handshake; ready is combinational in IDLE
//   {a,b}_we/addr/wdata/wstrb : request fields, held with valid
//   {a,b}_rsp_*             : response channel, held until rsp_ready
//   rf_wr_*                 : register-file write port (rf_wr_resp registered)
//   rf_rd_*                 : register-file read port (combinational result)
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_REGS   = 16,
  localparam int ADDR_WIDTH = $clog2(NUM_REGS),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port A
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [STRB_WIDTH-1:0] a_wstrb,
  output logic                  a_rsp_valid,
  input  logic                  a_rsp_ready,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  output logic [1:0]            a_rsp_resp,
  // port B
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [STRB_WIDTH-1:0] b_wstrb,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  output logic [1:0]            b_rsp_resp,
  // register file
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic [STRB_WIDTH-1:0] rf_wr_strb,
  input  logic [1:0]            rf_wr_resp,
  output logic                  rf_rd_en,
  output logic [ADDR_WIDTH-1:0] rf_rd_addr,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic [1:0]            rf_rd_resp
);

  state_t                state;
  logic                  last_gnt;
  logic                  cmd_port;
  logic                  cmd_we;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [1:0]            rsp_resp_q;
  logic [1:0]            rsp_resp_mux;

  logic [1:0]            gnt;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [STRB_WIDTH-1:0] sel_wstrb;
  logic                  rsp_ready_sel;

  rr_arbiter_2 u_arb (
    .req      ({b_valid, a_valid}),
    .last_gnt (last_gnt),
    .en       (state == IDLE),
    .gnt      (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  // Fields of whichever port is being granted this cycle.
  assign sel_we    = gnt[1] ? b_we    : a_we;
  assign sel_addr  = gnt[1] ? b_addr  : a_addr;
  assign sel_wdata = gnt[1] ? b_wdata : a_wdata;
  assign sel_wstrb = gnt[1] ? b_wstrb : a_wstrb;

  assign rsp_ready_sel = (cmd_port == PORT_B) ? b_rsp_ready : a_rsp_ready;

  // The rf address/data/strobe registers double as the command latch, so the
  // rf port is driven straight from flops during ACCESS.
  // NOTE: all state below uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_gnt    <= PORT_B;
      cmd_port    <= PORT_A;
      cmd_we      <= 1'b0;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_wr_addr  <= '0;
      rf_rd_addr  <= '0;
      rf_wr_data  <= '0;
      rf_wr_strb  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            cmd_port   <= gnt[1];
            last_gnt   <= gnt[1];
            cmd_we     <= sel_we;
            rf_wr_en   <= sel_we;
            rf_rd_en   <= !sel_we;
            rf_wr_addr <= sel_addr;
            rf_rd_addr <= sel_addr;
            rf_wr_data <= sel_wdata;
            rf_wr_strb <= sel_wstrb;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          rf_wr_en    <= 1'b0;
          rf_rd_en    <= 1'b0;
          rsp_data_q  <= cmd_we ? '0 : rf_rd_data;
          rsp_resp_q  <= cmd_we ? RESP_OKAY : rf_rd_resp;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_sel) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write responses come live from the rf: its registered response settled
  // after the ACCESS edge and cannot move while rf_wr_en is low.
  assign rsp_resp_mux = cmd_we ? rf_wr_resp : rsp_resp_q;

  assign a_rsp_valid = rsp_valid_q && (cmd_port == PORT_A);
  assign b_rsp_valid = rsp_valid_q && (cmd_port == PORT_B);
  assign a_rsp_data  = a_rsp_valid ? rsp_data_q   : '0;
  assign b_rsp_data  = b_rsp_valid ? rsp_data_q   : '0;
  assign a_rsp_resp  = a_rsp_valid ? rsp_resp_mux : 2'b00;
  assign b_rsp_resp  = b_rsp_valid ? rsp_resp_mux : 2'b00;

endmodule
